// File: rtl/fft_feed_pkg.sv
// Shared types and defaults for the FFT frame feeder.
//   feed_state_e : frame sequencer state (IDLE waits for a whole frame, STREAM emits it)
//   DEF_*        : default parameter values used by fft_frame_feeder
//   idx_width()  : width of the in-frame word index for a given frame length
package fft_feed_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feed_state_e;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_FFT_PTS    = 1024;
  localparam int unsigned DEF_PTS_W      = 12;
  localparam int unsigned DEF_FIFO_DEPTH = 2048;

  // Word index must be at least one bit wide even for a degenerate 1-point frame.
  function automatic int unsigned idx_width(input int unsigned pts);
    return (pts > 1) ? $clog2(pts) : 1;
  endfunction

  localparam int unsigned DEF_IDX_W = idx_width(DEF_FFT_PTS);
  localparam int unsigned DEF_CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with show-ahead read port.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data: store wr_data at the tail (caller guarantees room or a same-cycle pop)
//   pop          : discard the head word (caller guarantees !empty)
//   rd_data      : current head word, valid whenever !empty
//   count        : number of stored words, 0..DEPTH
//   full, empty  : count == DEPTH / count == 0
module sample_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers strobed mono audio samples and streams them into the FFT sink as
// gap-free FFT_PTS-word Avalon-ST frames.
//   clk, reset_n      : clock, asynchronous active-low reset
//   enable            : allow new frames to start
//   sample_valid/data : one-cycle sample strobe from capture (no backpressure)
//   src_valid/ready   : output handshake to the FFT sink
//   src_sop/eop/real  : frame markers and sample payload
//   src_imag/error    : constant zero
//   fft_pts           : constant FFT_PTS, fft_inverse: constant 0 (forward)
//   overflow          : sticky, a sample was dropped on a full buffer
//   frames_sent       : count of accepted eop words, wraps at 2^16
//   dbg_state         : current sequencer state
//
// Handshake: a word transfers on a rising edge where src_valid & src_ready.
// The output register reloads only when it is empty or transferring
// (!src_valid | src_ready); while src_valid & !src_ready, src_valid, src_real,
// src_sop and src_eop hold unchanged.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FFT_PTS    = DEF_FFT_PTS,
  parameter int unsigned PTS_W      = DEF_PTS_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [DATA_W-1:0] src_real,
  output logic [DATA_W-1:0] src_imag,
  output logic [1:0]        src_error,
  output logic [PTS_W-1:0]  fft_pts,
  output logic              fft_inverse,
  output logic              overflow,
  output logic [15:0]       frames_sent,
  output feed_state_e       dbg_state
);

  localparam int unsigned IDX_W = idx_width(FFT_PTS);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  feed_state_e       state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     count_after;

  logic              load;
  logic              word_load;
  logic              last_word;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (sample_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign load      = !src_valid || src_ready;
  // A frame only starts once fully buffered, so empty never blocks inside
  // STREAM; the guard just keeps stale data off the bus if it ever did.
  assign word_load = (state == STREAM) && load && !fifo_empty;
  assign fifo_pop  = word_load;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign fifo_push = sample_valid && (!fifo_full || fifo_pop);
  assign last_word = (idx == IDX_W'(FFT_PTS - 1));

  // Occupancy after this edge; lets the last word of a frame chain straight
  // into the next frame when another whole frame is already waiting.
  assign count_after = fifo_count - CW'(fifo_pop) + CW'(fifo_push);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (enable && (fifo_count >= CW'(FFT_PTS))) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (word_load) begin
          if (last_word) begin
            idx_next = '0;
            if (!(enable && (count_after >= CW'(FFT_PTS)))) begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_valid <= 1'b0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      src_real  <= '0;
    end else if (load) begin
      if (word_load) begin
        src_valid <= 1'b1;
        src_real  <= fifo_head;
        src_sop   <= (idx == '0);
        src_eop   <= last_word;
      end else begin
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        src_eop   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (sample_valid && !fifo_push) begin
        overflow <= 1'b1;
      end
      if (src_valid && src_ready && src_eop) begin
        frames_sent <= frames_sent + 1'b1;
      end
    end
  end

  assign src_imag    = '0;
  assign src_error   = 2'b00;
  assign fft_pts     = PTS_W'(FFT_PTS);
  assign fft_inverse = 1'b0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fft_frame_feeder.sv
`timescale 1ns/1ps
module tb_fft_frame_feeder;
  import fft_feed_pkg::*;

  localparam int DATA_W     = 16;
  localparam int FFT_PTS    = 1024;
  localparam int PTS_W      = 12;
  localparam int FIFO_DEPTH = 2048;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              src_valid;
  logic              src_ready = 1'b0;
  logic              src_sop;
  logic              src_eop;
  logic [DATA_W-1:0] src_real;
  logic [DATA_W-1:0] src_imag;
  logic [1:0]        src_error;
  logic [PTS_W-1:0]  fft_pts;
  logic              fft_inverse;
  logic              overflow;
  logic [15:0]       frames_sent;
  feed_state_e       dbg_state;

  always #5 clk = ~clk;

  fft_frame_feeder #(
    .DATA_W     (DATA_W),
    .FFT_PTS    (FFT_PTS),
    .PTS_W      (PTS_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_sop      (src_sop),
    .src_eop      (src_eop),
    .src_real     (src_real),
    .src_imag     (src_imag),
    .src_error    (src_error),
    .fft_pts      (fft_pts),
    .fft_inverse  (fft_inverse),
    .overflow     (overflow),
    .frames_sent  (frames_sent),
    .dbg_state    (dbg_state)
  );

  // ---------------- bench state / reference model ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];          // accepted samples not yet transferred
  int                word_idx = 0;      // position of next expected word in its frame
  int                xfer_cnt = 0;
  logic [15:0]       frames_m = '0;
  logic              ovf_m    = 1'b0;
  logic              chk_on     = 1'b0;
  logic              idle_chk   = 1'b0;
  logic              gap_chk    = 1'b0;
  logic              rand_ready = 1'b0;
  logic              ready_level = 1'b1;
  logic              prev_stall = 1'b0;
  logic [DATA_W+1:0] prev_word  = '0;
  int unsigned       cyc = 0;
  int unsigned       n_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    src_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Buffer model: a sample is kept while fewer than FIFO_DEPTH accepted
  // samples are still waiting to be transferred; otherwise it is lost.
  task automatic push_sample(input logic [DATA_W-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
    else ovf_m = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !src_valid) break;
    end
    check(name, {31'h0, src_valid, 32'(exp_q.size())}, 64'h0);
  endtask

  task automatic wait_word(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (word_idx >= target) break;
    end
    if (word_idx < target) check("wait_word_timeout", 64'(word_idx), 64'(target));
  endtask

  task automatic wait_frames(input logic [15:0] target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (frames_m == target) break;
    end
    if (frames_m != target) check("wait_frames_timeout", 64'(frames_m), 64'(target));
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (chk_on && reset_n) begin
      check("constants", {src_imag, src_error, fft_pts, fft_inverse},
            {16'h0, 2'b00, 12'(FFT_PTS), 1'b0});
      check("overflow", overflow, ovf_m);
      check("frames_sent", frames_sent, frames_m);
      if (idle_chk) check("idle_valid", src_valid, 1'b0);
      if (gap_chk && xfer_cnt > 0 && xfer_cnt < 2 * FFT_PTS) check("gap_valid", src_valid, 1'b1);
      if (prev_stall) check("hold", {src_valid, src_sop, src_eop, src_real}, {1'b1, prev_word});
      if (src_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", src_valid, 1'b0);
        end else begin
          check("data", src_real, exp_q[0]);
          check("sop", src_sop, word_idx == 0);
          check("eop", src_eop, word_idx == FFT_PTS - 1);
          if (src_ready) begin
            exp_q.delete(0);
            xfer_cnt++;
            if (word_idx == FFT_PTS - 1) begin
              word_idx = 0;
              frames_m = frames_m + 1'b1;
            end else begin
              word_idx++;
            end
          end
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_word  = {src_sop, src_eop, src_real};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    // reset state
    #3;
    check("reset_outputs", {src_valid, src_sop, src_eop, src_real}, '0);
    check("reset_counters", {overflow, frames_sent}, '0);
    check("reset_state", dbg_state, IDLE);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    chk_on  = 1'b1;
    idle_cycles(2);

    // 1: ramp frame, ready high, latency of first word
    enable = 1'b1;
    ready_level = 1'b1;
    for (int i = 0; i < FFT_PTS; i++) push_sample(DATA_W'(i));
    n_edge = cyc;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!src_valid && k < 10);
    check("sop_latency", cyc, n_edge + 2);
    check("first_word", {src_sop, src_real}, {1'b1, 16'h0000});
    wait_drain("t1_drain", 3000);
    @(negedge clk);
    check("t1_frames", frames_sent, 16'd1);

    // 2: ramp with random sample gaps and random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < FFT_PTS; i++) begin
      push_sample(DATA_W'(i));
      idle_cycles($urandom_range(0, 2));
    end
    wait_drain("t2_drain", 6000);
    rand_ready = 1'b0;

    // 3: 2048 random samples back to back, frames must be gap-free
    xfer_cnt = 0;
    gap_chk  = 1'b1;
    for (int i = 0; i < 2 * FFT_PTS; i++) push_sample(DATA_W'($urandom));
    wait_drain("t3_drain", 4000);
    gap_chk = 1'b0;

    // 4: overfill with sink stalled, one sample lost
    ready_level = 1'b0;
    enable = 1'b0;
    idle_cycles(2);
    for (int i = 0; i <= FIFO_DEPTH; i++) push_sample(DATA_W'(i));
    @(negedge clk);
    check("t4_overflow", overflow, 1'b1);
    enable = 1'b1;
    ready_level = 1'b1;
    wait_drain("t4_drain", 5000);
    @(negedge clk);
    check("t4_frames", frames_sent, 16'd6);

    // 5: reset in the middle of a frame
    for (int i = 0; i < FFT_PTS; i++) push_sample(DATA_W'(16'h4000 + i));
    wait_word(500, 3000);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", {src_valid, src_sop, src_eop}, 3'b000);
    check("async_reset_counters", {overflow, frames_sent}, 17'h0);
    exp_q.delete();
    word_idx = 0;
    frames_m = '0;
    ovf_m    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n  = 1'b1;
    idle_chk = 1'b1;
    for (int i = 0; i < FFT_PTS - 1; i++) push_sample(DATA_W'(16'h8000 + i));
    idle_cycles(10);
    idle_chk = 1'b0;
    push_sample(16'h83ff);
    wait_drain("t5_drain", 3000);

    // 6: enable dropped mid-frame with two frames buffered
    enable = 1'b0;
    for (int i = 0; i < 2 * FFT_PTS; i++) push_sample(DATA_W'($urandom));
    enable = 1'b1;
    wait_word(10, 200);
    enable = 1'b0;
    wait_frames(16'd2, 3000);
    idle_chk = 1'b1;
    idle_cycles(40);
    idle_chk = 1'b0;
    enable = 1'b1;
    wait_drain("t6_drain", 3000);
    @(negedge clk);
    check("t6_frames", frames_sent, 16'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
